phase_accumulator: RTL
======================

Name: phase_accumulator

Overview:
- Per-operator phase accumulator (NCO core) sitting directly downstream of the phase-increment stage.
- Holds one PHASE_ACC_WIDTH-bit accumulator for each of the 36 operators (2 banks x 18) in a single-port-write/single-port-read RAM.
- On each operator-slot strobe it adds that operator's phase increment to the stored value, or zeroes it on key-on.
- Outputs the top phase bits to the waveform/sine-lookup stage.

Parameters:
- PHASE_ACC_WIDTH, 20, accumulator width; matches the phase-increment output.
- PHASE_OUT_WIDTH, 10, phase bits passed to the waveform stage (accumulator MSBs).
- NUM_BANKS, 2, operator banks.
- OPS_PER_BANK, 18, operators per bank.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- op_valid_p2  in  1  one-cycle strobe: slot inputs below are valid this cycle.
- bank_num_p2  in  1  operator bank.
- op_num_p2  in  5  operator index within bank, 0..17.
- phase_inc_p2  in  PHASE_ACC_WIDTH  increment for this slot.
- key_on_pulse_p2  in  1  zero this operator's accumulator this slot.
- busy  out  1  high while the post-reset RAM clear runs.
- phase_valid_p4  out  1  phase_p4 is valid.
- phase_p4  out  PHASE_OUT_WIDTH  operator phase.

Behaviour:
- Address: addr = bank_num*18 + op_num, giving a 6-bit address in the range 0..35.
- op_num > 17 is illegal. Such a slot is dropped: no RAM write, phase_valid_p4 stays 0 for it.
- Reset (async assert): busy=1, phase_valid_p4=0, phase_p4=0, all pipeline valids cleared, FSM enters CLEAR with clear counter 0.
- CLEAR state:
  - Writes 0 to address clr_cnt each cycle, clr_cnt incrementing 0..35.
  - After the write to 35 it moves to RUN and deasserts busy in the same edge. Total 36 cycles after reset release.
  - op_valid_p2 is ignored while busy.
- RUN state: the pipeline operates as follows.
  - Edge ending p2: latch addr, inc, key_on and valid into p3 registers; issue the RAM read of addr.
  - p3: acc_old = RAM read data, or the forwarded value (see below). acc_new = key_on ? 0 : (acc_old + inc) mod 2^PHASE_ACC_WIDTH. Wrap-around is natural; no saturation.
  - Edge ending p3: write acc_new to addr when p3 valid; phase_p4 <= acc_new[MSB -: PHASE_OUT_WIDTH]; phase_valid_p4 <= p3 valid.
  - Latency: 2 clocks from op_valid_p2 to phase_valid_p4. Throughput: one slot per clock.
- Hazard forwarding:
  - If a slot's p3 address equals the address being written on the same edge its read was issued, acc_old takes that written value instead of RAM data.
  - Back-to-back identical addresses therefore accumulate correctly: two slots give 2*inc.
- Key-on with a nonzero increment yields acc_new=0. The increment resumes on the next slot for that operator.
- Reset asserted mid-operation: in-flight slots are discarded and CLEAR restarts from 0.
- phase_p4 holds its last value when phase_valid_p4=0.

Optional Feature:
- Macro: OPL3_PHASE_MOD_EN.
- Defined: adds input port modulation_p2 (signed, PHASE_OUT_WIDTH bits), pipelined to p3 alongside the slot.
  - phase_p4 = acc_new MSBs + modulation, computed mod 2^PHASE_OUT_WIDTH.
  - The stored accumulator is never modulated.
- Undefined: no port; phase_p4 is the accumulator MSBs only.

Test Plan:
- Reset release -> busy high exactly 36 cycles. A slot issued afterwards with bank 1, op 17, inc 0 gives phase_p4=0 at 2-cycle latency.
- op 3 bank 0, inc 0x00400, repeated 4 times with gaps -> phase_p4 = 0x001, 0x002, 0x003, 0x004.
- Same operator on back-to-back cycles, inc 0x00400, 3 cycles -> phase_p4 = 0x001, 0x002, 0x003 (forwarding exercised).
- Accumulator preloaded to 0xFFC00 via slots, then inc 0x00800 -> stored value 0x00400, phase_p4=0x001 (wrap).
- key_on_pulse with inc 0x12345 on an operator at phase 0x155 -> phase_p4=0x000; next slot with inc 0x00400 -> 0x001. Other operators unaffected.
- op_num=20 slot -> no phase_valid_p4, no RAM change. Reset mid-stream -> busy reasserts, all operators read back 0. With OPL3_PHASE_MOD_EN, modulation -1 at phase 0 -> phase_p4=0x3FF.

Source files
------------

// File: rtl/phase_accumulator.sv
// Per-operator phase accumulator (NCO core) with 36 accumulators in a 1W/1R RAM, post-reset clear and write-to-read forwarding.
// Optional phase modulation on the output path is enabled by defining OPL3_PHASE_MOD_EN.
module phase_accumulator #(
  parameter int PHASE_ACC_WIDTH = 20,
  parameter int PHASE_OUT_WIDTH = 10,
  parameter int NUM_BANKS       = 2,
  parameter int OPS_PER_BANK    = 18
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         op_valid_p2,
  input  logic                         bank_num_p2,
  input  logic [4:0]                   op_num_p2,
  input  logic [PHASE_ACC_WIDTH-1:0]   phase_inc_p2,
  input  logic                         key_on_pulse_p2,
`ifdef OPL3_PHASE_MOD_EN
  input  logic signed [PHASE_OUT_WIDTH-1:0] modulation_p2,
`endif
  output logic                         busy,
  output logic                         phase_valid_p4,
  output logic [PHASE_OUT_WIDTH-1:0]   phase_p4
);

  localparam int NUM_OPS = NUM_BANKS * OPS_PER_BANK;
  localparam int ADDR_W  = $clog2(NUM_OPS);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                      state;
  logic [ADDR_W-1:0]           clr_cnt;
  logic [PHASE_ACC_WIDTH-1:0]  mem [NUM_OPS];

  logic                        slot_legal;
  logic                        accept;
  logic [ADDR_W-1:0]           addr_p2;

  logic                        valid_p3;
  logic [ADDR_W-1:0]           addr_p3;
  logic [PHASE_ACC_WIDTH-1:0]  inc_p3;
  logic                        key_on_p3;
  logic                        fwd_p3;
  logic [PHASE_ACC_WIDTH-1:0]  fwd_data_p3;
  logic [PHASE_ACC_WIDTH-1:0]  rd_data_p3;
`ifdef OPL3_PHASE_MOD_EN
  logic signed [PHASE_OUT_WIDTH-1:0] mod_p3;
`endif

  logic [PHASE_ACC_WIDTH-1:0]  acc_old;
  logic [PHASE_ACC_WIDTH-1:0]  acc_new;
  logic [PHASE_OUT_WIDTH-1:0]  phase_out;
  logic                        wr_en;
  logic [ADDR_W-1:0]           wr_addr;
  logic [PHASE_ACC_WIDTH-1:0]  wr_data;

  // Illegal operator numbers are forced to address 0 so the read never leaves the array.
  always_comb begin
    slot_legal = op_num_p2 < 5'(OPS_PER_BANK);
    addr_p2    = '0;
    if (slot_legal) begin
      addr_p2 = bank_num_p2 ? ADDR_W'(OPS_PER_BANK) + ADDR_W'(op_num_p2) : ADDR_W'(op_num_p2);
    end
    accept = op_valid_p2 && slot_legal && (state == RUN);
  end

  always_comb begin
    acc_old = fwd_p3 ? fwd_data_p3 : rd_data_p3;
    acc_new = key_on_p3 ? '0 : acc_old + inc_p3;
`ifdef OPL3_PHASE_MOD_EN
    phase_out = acc_new[PHASE_ACC_WIDTH-1 -: PHASE_OUT_WIDTH] + $unsigned(mod_p3);
`else
    phase_out = acc_new[PHASE_ACC_WIDTH-1 -: PHASE_OUT_WIDTH];
`endif
    wr_en   = (state == CLEAR) || valid_p3;
    wr_addr = (state == CLEAR) ? clr_cnt : addr_p3;
    wr_data = (state == CLEAR) ? '0 : acc_new;
  end

  // A read issued on the same edge as a write to that address returns stale data; fwd_p3 covers it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data_p3 <= mem[addr_p2];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= CLEAR;
      clr_cnt        <= '0;
      busy           <= 1'b1;
      valid_p3       <= 1'b0;
      addr_p3        <= '0;
      inc_p3         <= '0;
      key_on_p3      <= 1'b0;
      fwd_p3         <= 1'b0;
      fwd_data_p3    <= '0;
`ifdef OPL3_PHASE_MOD_EN
      mod_p3         <= '0;
`endif
      phase_valid_p4 <= 1'b0;
      phase_p4       <= '0;
    end else begin
      if (state == CLEAR) begin
        if (clr_cnt == ADDR_W'(NUM_OPS - 1)) begin
          state <= RUN;
          busy  <= 1'b0;
        end else begin
          clr_cnt <= clr_cnt + 1'b1;
        end
      end
      valid_p3    <= accept;
      addr_p3     <= addr_p2;
      inc_p3      <= phase_inc_p2;
      key_on_p3   <= key_on_pulse_p2;
      fwd_p3      <= valid_p3 && (addr_p3 == addr_p2);
      fwd_data_p3 <= acc_new;
`ifdef OPL3_PHASE_MOD_EN
      mod_p3      <= modulation_p2;
`endif
      phase_valid_p4 <= valid_p3;
      if (valid_p3) begin
        phase_p4 <= phase_out;
      end
    end
  end

endmodule
